// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the double-buffered block frame buffer.
// Holds the default raster geometry, helpers that derive the block-grid
// dimensions from it, and the write-side FSM state type.
package frame_buffer_pkg;

    localparam int DEF_H_PIXELS   = 640;
    localparam int DEF_V_PIXELS   = 480;
    localparam int DEF_BLOCK_SIZE = 10;

    // Blocks per line
    function automatic int calc_cols(input int h_pixels, input int block_size);
        return h_pixels / block_size;
    endfunction

    // Block rows per frame
    function automatic int calc_rows(input int v_pixels, input int block_size);
        return v_pixels / block_size;
    endfunction

    // Blocks per frame (one bank entry per block)
    function automatic int calc_depth(input int cols, input int rows);
        return cols * rows;
    endfunction

    // Address width needed to index every block; never narrower than 1 bit
    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic {
        FB_WRITING = 1'b0,
        FB_PENDING = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port synchronous RAM holding one frame of block colours.
// Ports:
//   clk          - clock
//   we/waddr/wdata - write port, write happens on the rising edge
//   raddr        - read address
//   q            - registered read data, one cycle after raddr
// Contents are not reset.
module fb_bank_ram #(
    parameter int DEPTH   = 3072,
    parameter int PIXEL_W = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIXEL_W-1:0] q
);

    logic [PIXEL_W-1:0] mem_r [DEPTH];

    // Write port; the caller guarantees waddr < DEPTH whenever we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        q <= mem_r[raddr];
    end

endmodule

// File: rtl/block_frame_buffer.sv
// Double-buffered block-resolution frame buffer feeding the VGA output path.
// The writer fills the back bank and commits it; the banks swap roles only
// on the first blanking line so a displayed frame never mixes two banks.
// Ports:
//   clk, reset            - pixel clock, asynchronous active-high reset
//   hc, vc                - raster position
//   wr_en/wr_addr/wr_data - block write into the back bank
//   wr_commit             - back-bank frame complete (one-cycle pulse)
//   wr_ready              - writes and commit are accepted
//   swapped               - one-cycle pulse when the banks exchange roles
//   front_sel             - bank currently displayed
//   pixel_out/pixel_valid - block colour and visibility, 2 clocks after hc/vc
module block_frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int H_PIXELS   = DEF_H_PIXELS,
    parameter int V_PIXELS   = DEF_V_PIXELS,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int PIXEL_W    = 8,
    localparam int COLS   = calc_cols(H_PIXELS, BLOCK_SIZE),
    localparam int ROWS   = calc_rows(V_PIXELS, BLOCK_SIZE),
    localparam int DEPTH  = calc_depth(COLS, ROWS),
    localparam int ADDR_W = calc_addr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               wr_commit,
    output logic               wr_ready,
    output logic               swapped,
    output logic               front_sel,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid
);

    localparam logic [9:0]      H_LIMIT   = 10'(H_PIXELS);
    localparam logic [9:0]      V_LIMIT   = 10'(V_PIXELS);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    fb_state_t          state_r;
    logic               swap_point_s;
    logic               wr_in_range_s;
    logic               we0_s;
    logic               we1_s;
    logic               visible_s;
    logic [ADDR_W-1:0]  raddr_s;
    logic [ADDR_W-1:0]  raddr_r;
    logic               vis1_r;
    logic               sel1_r;
    logic               sel2_r;
    logic [PIXEL_W-1:0] q0_s;
    logic [PIXEL_W-1:0] q1_s;

    // Swap point: first pixel of the first blanking line
    always_comb begin
        swap_point_s = 1'b0;
        if ((hc == 10'd0) && (vc == V_LIMIT)) begin
            swap_point_s = 1'b1;
        end else begin
            swap_point_s = 1'b0;
        end
    end

    // Write steering: only the back bank (~front_sel) is ever written
    always_comb begin
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_EXT);
        we0_s = 1'b0;
        we1_s = 1'b0;
        if ((state_r == FB_WRITING) && wr_en && wr_in_range_s) begin
            we0_s = front_sel;
            we1_s = ~front_sel;
        end else begin
            we0_s = 1'b0;
            we1_s = 1'b0;
        end
    end

    // Write-side FSM: commit handshake and blanking-aligned bank swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= FB_WRITING;
            front_sel <= 1'b0;
            wr_ready  <= 1'b1;
            swapped   <= 1'b0;
        end else begin
            swapped <= 1'b0;
            case (state_r)
                FB_WRITING: begin
                    // A commit on the swap-point cycle only arms the swap
                    if (wr_commit) begin
                        state_r  <= FB_PENDING;
                        wr_ready <= 1'b0;
                    end
                end
                FB_PENDING: begin
                    if (swap_point_s) begin
                        state_r   <= FB_WRITING;
                        wr_ready  <= 1'b1;
                        front_sel <= ~front_sel;
                        swapped   <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= FB_WRITING;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Read stage 0: raster position to block address (0 outside the visible area)
    always_comb begin
        visible_s = (hc < H_LIMIT) && (vc < V_LIMIT);
        raddr_s   = '0;
        if (visible_s) begin
            raddr_s = ADDR_W'((int'(vc) / BLOCK_SIZE) * COLS + int'(hc) / BLOCK_SIZE);
        end else begin
            raddr_s = '0;
        end
    end

    // Read stages 1 and 2: address/visibility/bank select pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr_r     <= '0;
            vis1_r      <= 1'b0;
            sel1_r      <= 1'b0;
            sel2_r      <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            raddr_r     <= raddr_s;
            vis1_r      <= visible_s;
            sel1_r      <= front_sel;
            sel2_r      <= sel1_r;
            pixel_valid <= vis1_r;
        end
    end

    fb_bank_ram #(.DEPTH(DEPTH), .PIXEL_W(PIXEL_W)) u_bank0 (
        .clk   (clk),
        .we    (we0_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (raddr_r),
        .q     (q0_s)
    );

    fb_bank_ram #(.DEPTH(DEPTH), .PIXEL_W(PIXEL_W)) u_bank1 (
        .clk   (clk),
        .we    (we1_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (raddr_r),
        .q     (q1_s)
    );

    // Output mux: bank chosen by the select that travelled with the address
    always_comb begin
        pixel_out = '0;
        if (pixel_valid) begin
            pixel_out = sel2_r ? q1_s : q0_s;
        end else begin
            pixel_out = '0;
        end
    end

endmodule
